// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: per-channel two-flop synchronizer plus
// a stable-level qualification counter with registered press/release pulses.

module debounce_lane #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic rel
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // level held long enough: accept it and pulse the matching edge
        stable <= s2;
        cnt    <= '0;
        press  <= s2;
        rel    <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module button_debounce #(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    debounce_lane #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_raw[i]),
      .stable (btn_stable[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i])
    );
  end
endmodule
